// File: rtl/pm_readout_buffer.sv
// pm_readout_buffer: sequences pixel-matrix readout and buffers the data words in a FIFO.
// Each sample is strobed once, and its two words are pushed in the order dout_a, dout_b.
// A bus-side pop interface drains the FIFO.
// Optional feature macro: PM_READOUT_CHECKSUM_EN adds a running XOR checksum output.
module pm_readout_buffer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [15:0]                   len,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          pm_strobe,
  input  logic [31:0]                   pm_dout_a,
  input  logic [31:0]                   pm_dout_b,
  input  logic                          rd_req,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_empty
`ifdef PM_READOUT_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ROOM = 3'd1,
    STROBE    = 3'd2,
    CAP_A     = 3'd3,
    CAP_B     = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [15:0]     remaining_r, remaining_s;
  logic [31:0]     b_hold_r;
  logic            busy_r, done_r, pm_strobe_r;
  logic            done_s;
  logic            push_s, pop_s, room_s;
  logic [31:0]     push_data_s;
  logic [LW-1:0]   free_s;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r, level_s;
  logic            empty_r;
  logic [31:0]     rd_data_r;
  logic            rd_valid_r;

  // Pop is only honoured when the FIFO holds data.
  assign pop_s  = rd_req && !empty_r;
  // Free entries after this cycle's pop; a sample needs two entries before it is strobed.
  assign free_s = LW'(FIFO_DEPTH) - level_r + LW'(pop_s);
  assign room_s = (free_s >= LW'(2));

  // Next-state, push and completion decode; abort overrides everything and pushes nothing.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    push_s      = 1'b0;
    push_data_s = 32'd0;
    done_s      = 1'b0;
    if (abort) begin
      state_s     = IDLE;
      remaining_s = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (len != 16'd0) begin
              remaining_s = len;
              state_s     = WAIT_ROOM;
            end else begin
              done_s = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_ROOM: begin
          if (room_s) begin
            state_s = STROBE;
          end else begin
            state_s = WAIT_ROOM;
          end
        end
        STROBE: begin
          state_s = CAP_A;
        end
        CAP_A: begin
          push_s      = 1'b1;
          push_data_s = pm_dout_a;
          state_s     = CAP_B;
        end
        CAP_B: begin
          push_s      = 1'b1;
          push_data_s = b_hold_r;
          remaining_s = remaining_r - 16'd1;
          if (remaining_r == 16'd1) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = WAIT_ROOM;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Control state plus registered busy/done/strobe flags, which track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      remaining_r <= 16'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pm_strobe_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      busy_r      <= (state_s != IDLE);
      done_r      <= done_s;
      pm_strobe_r <= (state_s == STROBE);
    end
  end

  // Hold dout_b from CAP_A so that it can be pushed behind dout_a in CAP_B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_hold_r <= 32'd0;
    end else if (state_r == CAP_A) begin
      b_hold_r <= pm_dout_b;
    end else begin
      b_hold_r <= b_hold_r;
    end
  end

  // Occupancy bookkeeping; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LW'(1);
      2'b01:   level_s = level_r - LW'(1);
      default: level_s = level_r;
    endcase
  end

  // FIFO storage write port; contents are meaningful only between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= push_data_s;
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      empty_r    <= 1'b1;
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
    end else begin
      wr_ptr_r   <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
      rd_ptr_r   <= pop_s  ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      level_r    <= level_s;
      empty_r    <= (level_s == LW'(0));
      rd_data_r  <= pop_s ? mem[rd_ptr_r] : rd_data_r;
      rd_valid_r <= pop_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign pm_strobe  = pm_strobe_r;
  assign rd_data    = rd_data_r;
  assign rd_valid   = rd_valid_r;
  assign fifo_level = level_r;
  assign fifo_empty = empty_r;

`ifdef PM_READOUT_CHECKSUM_EN
  logic [31:0] checksum_r;
  logic        start_ok_s;

  function automatic logic [31:0] csum_next(input logic [31:0] acc, input logic [31:0] word);
    return acc ^ word;
  endfunction

  assign start_ok_s = (state_r == IDLE) && start && !abort;

  // Running XOR over every pushed word, restarted by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= 32'd0;
    end else if (start_ok_s) begin
      checksum_r <= 32'd0;
    end else if (push_s) begin
      checksum_r <= csum_next(checksum_r, push_data_s);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_pm_readout_buffer.sv
// Self-checking bench for pm_readout_buffer (depth-16 and depth-4 instances).
module tb_pm_readout_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start16, abort16, rd_req16;
  logic [15:0] len16;
  logic [31:0] a16, b16, rd_data16;
  logic        busy16, done16, strobe16, rd_valid16, empty16;
  logic [4:0]  level16;

  logic        start4, abort4, rd_req4;
  logic [15:0] len4;
  logic [31:0] a4, b4, rd_data4;
  logic        busy4, done4, strobe4, rd_valid4, empty4;
  logic [2:0]  level4;

`ifdef PM_READOUT_CHECKSUM_EN
  logic [31:0] csum16, csum4;
`endif

  pm_readout_buffer #(.FIFO_DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .len(len16), .abort(abort16),
    .busy(busy16), .done(done16), .pm_strobe(strobe16),
    .pm_dout_a(a16), .pm_dout_b(b16), .rd_req(rd_req16),
    .rd_data(rd_data16), .rd_valid(rd_valid16),
    .fifo_level(level16), .fifo_empty(empty16)
`ifdef PM_READOUT_CHECKSUM_EN
    , .checksum(csum16)
`endif
  );

  pm_readout_buffer #(.FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .len(len4), .abort(abort4),
    .busy(busy4), .done(done4), .pm_strobe(strobe4),
    .pm_dout_a(a4), .pm_dout_b(b4), .rd_req(rd_req4),
    .rd_data(rd_data4), .rd_valid(rd_valid4),
    .fifo_level(level4), .fifo_empty(empty4)
`ifdef PM_READOUT_CHECKSUM_EN
    , .checksum(csum4)
`endif
  );

  // Pixel-matrix models: the words for sample n are base_a+n / base_b+n, valid the cycle after the strobe.
  logic        clr_idx;
  logic [31:0] base_a, base_b, idx16, idx4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx16 <= 32'd0; a16 <= 32'd0; b16 <= 32'd0;
    end else if (clr_idx) begin
      idx16 <= 32'd0;
    end else if (strobe16) begin
      a16 <= base_a + idx16; b16 <= base_b + idx16; idx16 <= idx16 + 32'd1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx4 <= 32'd0; a4 <= 32'd0; b4 <= 32'd0;
    end else if (clr_idx) begin
      idx4 <= 32'd0;
    end else if (strobe4) begin
      a4 <= base_a + idx4; b4 <= base_b + idx4; idx4 <= idx4 + 32'd1;
    end
  end

  // Free-running event counters; tests take differences of them.
  int n_done16 = 0, n_strobe16 = 0, n_busy16 = 0, n_done4 = 0, n_strobe4 = 0;
  always @(posedge clk) begin
    if (done16)   n_done16   <= n_done16 + 1;
    if (strobe16) n_strobe16 <= n_strobe16 + 1;
    if (busy16)   n_busy16   <= n_busy16 + 1;
    if (done4)    n_done4    <= n_done4 + 1;
    if (strobe4)  n_strobe4  <= n_strobe4 + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    clr_idx = 1'b1;
    @(negedge clk);
    clr_idx = 1'b0;
  endtask

  task automatic pulse_start16(input logic [15:0] l);
    start16 = 1'b1; len16 = l;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // Pop nwords back to back and compare each word against the a/b interleave.
  task automatic drain16(input int nwords, input logic [31:0] ba, input logic [31:0] bb, input string tag);
    logic [31:0] exp;
    for (int i = 0; i < nwords; i++) begin
      rd_req16 = 1'b1;
      @(negedge clk);
      rd_req16 = 1'b0;
      exp = (i % 2 == 0) ? (ba + 32'(i / 2)) : (bb + 32'(i / 2));
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, rd_valid16}, 32'd1);
      chk($sformatf("%s_data%0d", tag, i), rd_data16, exp);
    end
    chk($sformatf("%s_empty", tag), {31'd0, empty16}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] len;
    logic [31:0] ba;
    logic [31:0] bb;
    bit          restart;
    int          exp_words;
    int          exp_done;
    int          exp_strobes;
    int          exp_busy;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, s0, b0, widx, maxlev;
    logic [31:0] exp;

    tbl[0] = '{16'd3, 32'h1000_0000, 32'h2000_0000, 1'b0, 6,  1, 3, 12};
    tbl[1] = '{16'd1, 32'h3000_0000, 32'h4000_0000, 1'b0, 2,  1, 1, 4};
    tbl[2] = '{16'd0, 32'h1000_0000, 32'h2000_0000, 1'b0, 0,  1, 0, 0};
    tbl[3] = '{16'd3, 32'h5000_0000, 32'h6000_0000, 1'b1, 6,  1, 3, 12};

    start16 = 1'b0; abort16 = 1'b0; rd_req16 = 1'b0; len16 = 16'd0;
    start4  = 1'b0; abort4  = 1'b0; rd_req4  = 1'b0; len4  = 16'd0;
    clr_idx = 1'b0; base_a = 32'h1000_0000; base_b = 32'h2000_0000;
    rst_n = 1'b0;
    cyc(2);
    chk("rst_busy",   {31'd0, busy16},     32'd0);
    chk("rst_done",   {31'd0, done16},     32'd0);
    chk("rst_strobe", {31'd0, strobe16},   32'd0);
    chk("rst_rvalid", {31'd0, rd_valid16}, 32'd0);
    chk("rst_rdata",  rd_data16,           32'd0);
    chk("rst_level",  {27'd0, level16},    32'd0);
    chk("rst_empty",  {31'd0, empty16},    32'd1);
    rst_n = 1'b1;
    cyc(2);

    // Pop request on an empty FIFO is ignored.
    rd_req16 = 1'b1;
    cyc(1);
    rd_req16 = 1'b0;
    chk("empty_rd_valid", {31'd0, rd_valid16}, 32'd0);
    chk("empty_rd_level", {27'd0, level16},    32'd0);

    // Zero-length start: done on the next cycle, never busy, no strobe.
    s0 = n_strobe16;
    pulse_start16(16'd0);
    chk("len0_done",  {31'd0, done16}, 32'd1);
    chk("len0_busy",  {31'd0, busy16}, 32'd0);
    cyc(1);
    chk("len0_done_once", {31'd0, done16}, 32'd0);
    chk("len0_busy2", {31'd0, busy16}, 32'd0);
    chk("len0_strobes", 32'(n_strobe16 - s0), 32'd0);

    // Table of complete readouts without reads, then a full drain in order.
    for (int i = 0; i < 4; i++) begin
      clr();
      base_a = tbl[i].ba; base_b = tbl[i].bb;
      d0 = n_done16; s0 = n_strobe16; b0 = n_busy16;
      pulse_start16(tbl[i].len);
      for (int k = 0; k < 4 * int'(tbl[i].len) + 4; k++) begin
        if (tbl[i].restart && k == 4) begin
          start16 = 1'b1; len16 = 16'd9;
        end else begin
          start16 = 1'b0;
        end
        @(negedge clk);
      end
      start16 = 1'b0;
      chk($sformatf("t%0d_done", i),    32'(n_done16 - d0),   32'(tbl[i].exp_done));
      chk($sformatf("t%0d_strobes", i), 32'(n_strobe16 - s0), 32'(tbl[i].exp_strobes));
      chk($sformatf("t%0d_busycyc", i), 32'(n_busy16 - b0),   32'(tbl[i].exp_busy));
      chk($sformatf("t%0d_level", i),   {27'd0, level16},     32'(tbl[i].exp_words));
      drain16(tbl[i].exp_words, tbl[i].ba, tbl[i].bb, $sformatf("t%0d", i));
    end

    // Abort in CAP_B of the second sample: b1 is dropped, no done.
    clr();
    base_a = 32'h1000_0000; base_b = 32'h2000_0000;
    d0 = n_done16; s0 = n_strobe16;
    pulse_start16(16'd5);
    cyc(7);
    abort16 = 1'b1;
    cyc(1);
    abort16 = 1'b0;
    chk("abort_busy",  {31'd0, busy16},  32'd0);
    chk("abort_level", {27'd0, level16}, 32'd3);
    cyc(5);
    chk("abort_nodone",  32'(n_done16 - d0),   32'd0);
    chk("abort_strobes", 32'(n_strobe16 - s0), 32'd2);
    chk("abort_level2",  {27'd0, level16},     32'd3);
    drain16(3, 32'h1000_0000, 32'h2000_0000, "abort");

    // Continuous reads during a len=8 run: level stays low, 16 words in order.
    clr();
    d0 = n_done16; widx = 0; maxlev = 0;
    rd_req16 = 1'b1;
    pulse_start16(16'd8);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (int'(level16) > maxlev) maxlev = int'(level16);
      if (rd_valid16) begin
        exp = (widx % 2 == 0) ? (base_a + 32'(widx / 2)) : (base_b + 32'(widx / 2));
        chk($sformatf("stream_data%0d", widx), rd_data16, exp);
        widx++;
      end
    end
    rd_req16 = 1'b0;
    chk("stream_words", 32'(widx), 32'd16);
    chk("stream_maxlevel_le2", {31'd0, (maxlev > 2)}, 32'd0);
    chk("stream_done", 32'(n_done16 - d0), 32'd1);
    chk("stream_empty", {31'd0, empty16}, 32'd1);

    // Depth-4 instance: stalls in WAIT_ROOM with a full FIFO, resumes once room frees.
    clr();
    d0 = n_done4; s0 = n_strobe4;
    start4 = 1'b1; len4 = 16'd4;
    @(negedge clk);
    start4 = 1'b0;
    cyc(20);
    chk("stall_level",   {29'd0, level4},       32'd4);
    chk("stall_busy",    {31'd0, busy4},        32'd1);
    chk("stall_strobes", 32'(n_strobe4 - s0),   32'd2);
    chk("stall_nodone",  32'(n_done4 - d0),     32'd0);
    widx = 0;
    rd_req4 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_valid4) begin
        exp = (widx % 2 == 0) ? (base_a + 32'(widx / 2)) : (base_b + 32'(widx / 2));
        chk($sformatf("d4_data%0d", widx), rd_data4, exp);
        widx++;
      end
    end
    rd_req4 = 1'b0;
    chk("d4_words", 32'(widx), 32'd8);
    chk("d4_done",  32'(n_done4 - d0), 32'd1);
    chk("d4_empty", {31'd0, empty4}, 32'd1);

`ifdef PM_READOUT_CHECKSUM_EN
    // Checksum of one sample, then cleared by a fresh (zero-length) start.
    clr();
    base_a = 32'hA5A5_0000; base_b = 32'h0000_5A5A;
    pulse_start16(16'd1);
    cyc(6);
    chk("csum_value", csum16, 32'hA5A5_5A5A);
    drain16(2, 32'hA5A5_0000, 32'h0000_5A5A, "csum");
    pulse_start16(16'd0);
    chk("csum_cleared", csum16, 32'd0);
`endif

    // Asynchronous reset in the middle of a readout.
    clr();
    base_a = 32'h1000_0000; base_b = 32'h2000_0000;
    pulse_start16(16'd4);
    cyc(9);
    chk("mid_busy_before", {31'd0, busy16}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, busy16},     32'd0);
    chk("mid_rst_done",   {31'd0, done16},     32'd0);
    chk("mid_rst_strobe", {31'd0, strobe16},   32'd0);
    chk("mid_rst_rvalid", {31'd0, rd_valid16}, 32'd0);
    chk("mid_rst_rdata",  rd_data16,           32'd0);
    chk("mid_rst_level",  {27'd0, level16},    32'd0);
    chk("mid_rst_empty",  {31'd0, empty16},    32'd1);
`ifdef PM_READOUT_CHECKSUM_EN
    chk("mid_rst_csum",   csum16,              32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    clr();
    d0 = n_done16;
    pulse_start16(16'd1);
    cyc(6);
    chk("post_rst_level", {27'd0, level16}, 32'd2);
    chk("post_rst_done",  32'(n_done16 - d0), 32'd1);
    drain16(2, 32'h1000_0000, 32'h2000_0000, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
